fast_corner_collector: RTL and testbench

Sink-side collector for the FAST_with_NMS corner stream. Captures each (x_coord, y_coord) corner event qualified by `iscorner`, tags the last corner of every frame, and buffers the records in a FIFO. Records drain through a valid/ready read port toward a host or DMA. It sits directly downstream of the detector and shares its `clk`/`ce` domain.

---
 rtl/fast_pkg.sv | 24 ++
 rtl/fast_corner_collector_if.sv | 34 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/fast_corner_collector.sv | 144 ++++++++++++++
 tb/tb_fast_corner_collector.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - shared types and constants for the FAST corner collector
// Record and staging layouts are fixed at DEFAULT_COORD_WIDTH bits per coordinate.
package fast_pkg;

  localparam int DEFAULT_COORD_WIDTH = 10;

  typedef struct packed {
    logic                           last;
    logic                           empty;
    logic [DEFAULT_COORD_WIDTH-1:0] y;
    logic [DEFAULT_COORD_WIDTH-1:0] x;
  } corner_rec_t;

  typedef struct packed {
    logic                           valid;
    logic                           last;
    logic [DEFAULT_COORD_WIDTH-1:0] y;
    logic [DEFAULT_COORD_WIDTH-1:0] x;
  } corner_stg_t;

  // Marker written for a frame that produced no corners at all.
  localparam corner_rec_t CORNER_REC_EMPTY = '{last: 1'b1, empty: 1'b1, y: '0, x: '0};

endpackage

// File: rtl/fast_corner_collector_if.sv
// rtl/fast_corner_collector_if.sv - valid/ready record read port of the corner collector
// The collector drives the master side; the host or DMA engine takes the slave side.
interface fast_corner_collector_if
  import fast_pkg::*;
#(
  parameter int COORD_WIDTH = DEFAULT_COORD_WIDTH
) ();

  logic                   m_valid;
  logic                   m_ready;
  logic [COORD_WIDTH-1:0] m_x;
  logic [COORD_WIDTH-1:0] m_y;
  logic                   m_last;
  logic                   m_empty;

  modport master (
    output m_valid,
    output m_x,
    output m_y,
    output m_last,
    output m_empty,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_x,
    input  m_y,
    input  m_last,
    input  m_empty,
    output m_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with full/empty flags
// A write on a full FIFO is still accepted when a read retires the head in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_rd_en && !o_empty;
  assign w_push  = i_wr_en && (!o_full || w_pop);

  // Head is gated so the read port shows zeros rather than stale storage while empty.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fast_corner_collector.sv
// rtl/fast_corner_collector.sv - stages, frame-tags and buffers FAST corner events (CORNER_COLLECTOR_BOUNDS_CHECK_EN adds a coordinate bounds check)
// One staging slot delays each corner until the next event so the final one can carry last.
module fast_corner_collector
  import fast_pkg::*;
#(
  parameter int COL_NUM     = 30,
  parameter int ROW_NUM     = 20,
  parameter int COORD_WIDTH = DEFAULT_COORD_WIDTH,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   iscorner,
  input  logic [COORD_WIDTH-1:0] x_coord,
  input  logic [COORD_WIDTH-1:0] y_coord,
  input  logic                   eof,
  input  logic                   clr_ovf,
  fast_corner_collector_if.master m_if,
  output logic                   overflow,
  output logic                   range_err,
  output logic [CNT_WIDTH-1:0]   frame_corners,
  output logic [CNT_WIDTH-1:0]   frame_cnt
);

  if (COORD_WIDTH != DEFAULT_COORD_WIDTH || COL_NUM < 1 || ROW_NUM < 1 ||
      COL_NUM >= (1 << COORD_WIDTH) || ROW_NUM >= (1 << COORD_WIDTH)) begin : g_bad_dims
    $error("fast_corner_collector: image size or coordinate width unsupported");
  end

  corner_stg_t          r_stg;
  logic [CNT_WIDTH-1:0] r_run_cnt;
  logic [CNT_WIDTH-1:0] r_frame_corners;
  logic [CNT_WIDTH-1:0] r_frame_cnt;
  logic                 r_overflow;
  logic                 r_range_err;

  logic                 w_range_hit;
  logic                 w_corner;
  logic                 w_eof;
  logic                 w_push_stg;
  logic                 w_push_mark;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_drop;
  logic [CNT_WIDTH-1:0] w_run_next;
  corner_rec_t          w_wr_rec;
  corner_rec_t          w_rd_rec;

`ifdef CORNER_COLLECTOR_BOUNDS_CHECK_EN
  localparam logic [COORD_WIDTH-1:0] X_LIM = COORD_WIDTH'(COL_NUM);
  localparam logic [COORD_WIDTH-1:0] Y_LIM = COORD_WIDTH'(ROW_NUM);

  assign w_range_hit = ce && iscorner && ((x_coord >= X_LIM) || (y_coord >= Y_LIM));
`else
  assign w_range_hit = 1'b0;
`endif

  // A rejected corner behaves as if no corner arrived; a coincident eof still closes the frame.
  assign w_corner    = ce && iscorner && !w_range_hit;
  assign w_eof       = ce && eof;
  assign w_push_stg  = r_stg.valid && (r_stg.last || w_corner || w_eof);
  assign w_push_mark = w_eof && !w_corner && !r_stg.valid;
  assign w_push      = w_push_stg || w_push_mark;
  assign w_pop       = !w_empty && m_if.m_ready;
  assign w_drop      = w_push && w_full && !w_pop;
  assign w_run_next  = (w_corner && (r_run_cnt != '1)) ? r_run_cnt + CNT_WIDTH'(1) : r_run_cnt;

  always_comb begin
    w_wr_rec = CORNER_REC_EMPTY;
    if (w_push_stg) begin
      w_wr_rec.last  = r_stg.last || (w_eof && !w_corner);
      w_wr_rec.empty = 1'b0;
      w_wr_rec.y     = r_stg.y;
      w_wr_rec.x     = r_stg.x;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(corner_rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_push),
    .i_wr_data (w_wr_rec),
    .o_full    (w_full),
    .i_rd_en   (m_if.m_ready),
    .o_rd_data (w_rd_rec),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg           <= '0;
      r_run_cnt       <= '0;
      r_frame_corners <= '0;
      r_frame_cnt     <= '0;
      r_overflow      <= 1'b0;
      r_range_err     <= 1'b0;
    end else begin
      // The detector cannot be stalled, so staging advances even when the write is dropped.
      if (w_corner) begin
        r_stg <= '{valid: 1'b1, last: w_eof, y: y_coord, x: x_coord};
      end else if (w_push_stg) begin
        r_stg.valid <= 1'b0;
      end

      if (w_eof) begin
        r_frame_corners <= w_run_next;
        r_run_cnt       <= '0;
        r_frame_cnt     <= r_frame_cnt + CNT_WIDTH'(1);
      end else begin
        r_run_cnt <= w_run_next;
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end

      if (w_range_hit) begin
        r_range_err <= 1'b1;
      end else if (clr_ovf) begin
        r_range_err <= 1'b0;
      end
    end
  end

  assign m_if.m_valid  = !w_empty;
  assign m_if.m_x      = w_rd_rec.x;
  assign m_if.m_y      = w_rd_rec.y;
  assign m_if.m_last   = w_rd_rec.last;
  assign m_if.m_empty  = w_rd_rec.empty;
  assign overflow      = r_overflow;
  assign range_err     = r_range_err;
  assign frame_corners = r_frame_corners;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_fast_corner_collector.sv
// tb/tb_fast_corner_collector.sv - directed and randomized bench for fast_corner_collector
module tb_fast_corner_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       iscorner = 1'b0;
  logic       eof = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [9:0] x_coord = '0;
  logic [9:0] y_coord = '0;
  logic       overflow;
  logic       range_err;
  logic [15:0] frame_corners;
  logic [15:0] frame_cnt;

  fast_corner_collector_if #(.COORD_WIDTH(10)) m_if ();

  fast_corner_collector #(
    .COL_NUM     (30),
    .ROW_NUM     (20),
    .COORD_WIDTH (10),
    .FIFO_DEPTH  (16),
    .CNT_WIDTH   (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ce            (ce),
    .iscorner      (iscorner),
    .x_coord       (x_coord),
    .y_coord       (y_coord),
    .eof           (eof),
    .clr_ovf       (clr_ovf),
    .m_if          (m_if),
    .overflow      (overflow),
    .range_err     (range_err),
    .frame_corners (frame_corners),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit last;
    bit empty;
  } rec_t;

  int   vectors = 0;
  int   miscompares = 0;
  rec_t exp_q[$];
  bit   cur_has;
  int   run_m, fc_m, cnt_m;
  bit   ovf_m, rng_m;
  int   since_eof;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    cur_has = 0;
    run_m = 0;
    fc_m = 0;
    cnt_m = 0;
    ovf_m = 0;
    rng_m = 0;
  endtask

  // Frame-level view: every accepted corner becomes a record in arrival order; eof marks the
  // frame's final record as last, or emits an empty marker when the frame had none.
  task automatic model_edge();
    bit c, e, rhit;
    if (!rst_n) return;
    c = ce && iscorner;
    e = ce && eof;
    rhit = 0;
`ifdef CORNER_COLLECTOR_BOUNDS_CHECK_EN
    if (c && (x_coord >= 30 || y_coord >= 20)) begin
      c = 0;
      rhit = 1;
    end
`endif
    if (rhit) rng_m = 1;
    else if (clr_ovf) rng_m = 0;
    if (clr_ovf) ovf_m = 0;
    if (c) begin
      exp_q.push_back('{x: int'(x_coord), y: int'(y_coord), last: e, empty: 1'b0});
      cur_has = 1;
    end
    if (e) begin
      if (!c) begin
        if (cur_has) exp_q[exp_q.size()-1].last = 1;
        else exp_q.push_back('{x: 0, y: 0, last: 1'b1, empty: 1'b1});
      end
      fc_m = (run_m + int'(c) > 65535) ? 65535 : run_m + int'(c);
      run_m = 0;
      cnt_m = (cnt_m + 1) % 65536;
      cur_has = 0;
    end else if (c) begin
      run_m = (run_m == 65535) ? run_m : run_m + 1;
    end
  endtask

  task automatic step();
    rec_t r;
    @(negedge clk);
    if (m_if.m_valid && m_if.m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        check("rec_x", 32'(m_if.m_x), 32'(r.x));
        check("rec_y", 32'(m_if.m_y), 32'(r.y));
        check("rec_last", 32'(m_if.m_last), 32'(r.last));
        check("rec_empty", 32'(m_if.m_empty), 32'(r.empty));
      end
    end
    check("frame_corners", 32'(frame_corners), 32'(fc_m));
    check("frame_cnt", 32'(frame_cnt), 32'(cnt_m));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("range_err", 32'(range_err), 32'(rng_m));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    iscorner = 0;
    eof = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic corner(input int x, input int y, input bit e);
    iscorner = 1;
    x_coord = 10'(x);
    y_coord = 10'(y);
    eof = e;
    step();
    iscorner = 0;
    eof = 0;
  endtask

  task automatic end_frame();
    iscorner = 0;
    eof = 1;
    step();
    eof = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_clear();
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_clear();
    m_if.m_ready = 1'b1;
    #2;
    check("rst_m_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_m_x", 32'(m_if.m_x), 32'd0);
    check("rst_m_y", 32'(m_if.m_y), 32'd0);
    check("rst_m_last", 32'(m_if.m_last), 32'd0);
    check("rst_m_empty", 32'(m_if.m_empty), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    check("rst_frame_corners", 32'(frame_corners), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    step();
    step();
    rst_n = 1;
    ce = 1;
    idle(2);

    // Single corner, frame closed ten cycles later.
    corner(3, 3, 0);
    idle(9);
    end_frame();
    idle(3);
    check("t1_frame_corners", 32'(frame_corners), 32'd1);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Second corner coincident with eof.
    corner(3, 3, 0);
    idle(1);
    corner(10, 5, 1);
    idle(3);
    check("t2_frame_corners", 32'(frame_corners), 32'd2);

    // Staged last record reaches the port one cycle after its own write edge.
    m_if.m_ready = 0;
    corner(12, 7, 1);
    check("lat_staged", 32'(m_if.m_valid), 32'd0);
    idle(1);
    check("lat_visible", 32'(m_if.m_valid), 32'd1);
    check("lat_last", 32'(m_if.m_last), 32'd1);
    check("lat_x", 32'(m_if.m_x), 32'd12);
    m_if.m_ready = 1;
    idle(3);

    // Empty frame marker.
    end_frame();
    idle(3);
    check("t3_frame_corners", 32'(frame_corners), 32'd0);

    // Overflow: 20 corners into a 16-deep FIFO with the consumer stalled.
    m_if.m_ready = 0;
    for (int i = 0; i < 20; i++) begin
      corner(i, 1, 0);
      while (exp_q.size() - int'(cur_has) > 16) begin
        exp_q.delete(exp_q.size() - 1 - int'(cur_has));
        ovf_m = 1;
      end
    end
    end_frame();
    while (exp_q.size() - int'(cur_has) > 16) begin
      exp_q.delete(exp_q.size() - 1 - int'(cur_has));
      ovf_m = 1;
    end
    idle(1);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_frame_corners", 32'(frame_corners), 32'd20);
    check("ovf_full_valid", 32'(m_if.m_valid), 32'd1);
    clr_ovf = 1;
    step();
    clr_ovf = 0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Push into a full FIFO while the head is being read: no drop.
    corner(5, 6, 0);
    m_if.m_ready = 1;
    corner(7, 8, 0);
    check("full_push_pop_ovf", 32'(overflow), 32'd0);
    idle(20);
    end_frame();
    idle(3);

    // Events while ce is low are ignored.
    ce = 0;
    iscorner = 1;
    x_coord = 10'd4;
    y_coord = 10'd4;
    eof = 1;
    step();
    eof = 0;
    step();
    eof = 1;
    step();
    iscorner = 0;
    eof = 0;
    check("ce0_no_record", 32'(m_if.m_valid), 32'd0);
    ce = 1;
    idle(3);

    // Corner one column past the image edge.
    corner(30, 4, 0);
    idle(2);
    end_frame();
    idle(3);
`ifdef CORNER_COLLECTOR_BOUNDS_CHECK_EN
    check("x30_range_err", 32'(range_err), 32'd1);
    check("x30_frame_corners", 32'(frame_corners), 32'd0);
`else
    check("x30_range_err", 32'(range_err), 32'd0);
    check("x30_frame_corners", 32'(frame_corners), 32'd1);
`endif
    clr_ovf = 1;
    step();
    clr_ovf = 0;
    idle(2);

    // Reset in mid-frame discards the partial frame.
    corner(1, 1, 0);
    corner(2, 2, 0);
    do_reset();
    check("mid_rst_valid", 32'(m_if.m_valid), 32'd0);
    idle(2);
    end_frame();
    idle(3);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd1);
    check("mid_rst_frame_corners", 32'(frame_corners), 32'd0);

    // Randomized traffic with occasional consumer stalls.
    since_eof = 10;
    for (int i = 0; i < 800; i++) begin
      ce = ($urandom % 8) != 0;
      iscorner = ($urandom % 3) == 0;
      x_coord = 10'($urandom % 30);
      y_coord = 10'($urandom % 20);
      eof = (since_eof >= 2) && (($urandom % 12) == 0);
      m_if.m_ready = ($urandom % 4) != 0;
      step();
      since_eof = eof ? 1 : since_eof + 1;
    end
    ce = 1;
    iscorner = 0;
    eof = 0;
    m_if.m_ready = 1;
    idle(2);
    end_frame();
    idle(40);
    check("drain_leftover", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(m_if.m_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
